// File: rtl/mem0_mem1_reg_pkg.sv
// Shared TLB exception codes, MEM1 block-FSM encodings and the payload record for the MEM0->MEM1 register.
package mem0_mem1_reg_pkg;

    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;

    localparam logic STATE_OPEN  = 1'b0;
    localparam logic STATE_BLOCK = 1'b1;

    typedef enum logic {
        OPEN  = STATE_OPEN,
        BLOCK = STATE_BLOCK
    } m1_state_e;

    typedef struct packed {
        logic        exc;
        logic [4:0]  exccode;
        logic        tlbRefill;
        logic [31:0] badVaddr;
    } exc_info_t;

    // kseg1 is the unmapped, uncached window 0xA000_0000-0xBFFF_FFFF
    function automatic logic isKseg1(input logic [31:0] vaddr);
        return vaddr[31:29] == 3'b101;
    endfunction

endpackage

// File: rtl/mem0_mem1_reg_tlb_exc_encode.sv
// Combinational priority encoder: older exception > TLBL > TLBS > Mod.
module tlb_exc_encode
    import mem0_mem1_reg_pkg::*;
(
    input  logic        prev_exc_i,
    input  logic [4:0]  prev_exccode_i,
    input  logic        refill_l_i,
    input  logic        invalid_l_i,
    input  logic        refill_s_i,
    input  logic        invalid_s_i,
    input  logic        mod_i,
    input  logic [31:0] vaddr_i,
    output exc_info_t   info_o
);

    always_comb begin
        info_o = '0;
        if (prev_exc_i) begin
            info_o.exc     = 1'b1;
            info_o.exccode = prev_exccode_i;
        end else if (refill_l_i || invalid_l_i) begin
            // only the refill flavour uses the refill vector (offset 0x000)
            info_o.exc       = 1'b1;
            info_o.exccode   = EXCCODE_TLBL;
            info_o.tlbRefill = refill_l_i;
            info_o.badVaddr  = vaddr_i;
        end else if (refill_s_i || invalid_s_i) begin
            info_o.exc       = 1'b1;
            info_o.exccode   = EXCCODE_TLBS;
            info_o.tlbRefill = refill_s_i;
            info_o.badVaddr  = vaddr_i;
        end else if (mod_i) begin
            info_o.exc      = 1'b1;
            info_o.exccode  = EXCCODE_MOD;
            info_o.badVaddr = vaddr_i;
        end
    end

endmodule

// File: rtl/mem0_mem1_reg.sv
// MEM0->MEM1 pipeline register with TLB exception encoding and a request-blocking FSM.
// Optional saturating TLB-exception counter enabled by TLB_EXC_CNT_EN.
module mem0_mem1_reg
    import mem0_mem1_reg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        m0_to_m1_valid,
    output logic        m1_allowin,
    input  logic        m1_ready_go,
    input  logic        m2_allowin,
    output logic        m1_to_m2_valid,
    input  logic [31:0] m0_vaddr,
    input  logic [31:0] m0_paddr,
    input  logic        m0_is_load,
    input  logic        m0_is_store,
    input  logic        m0_is_cache,
    input  logic        m0_prev_exc,
    input  logic [4:0]  m0_prev_exccode,
    input  logic        m0_tlb_refill_l,
    input  logic        m0_tlb_refill_s,
    input  logic        m0_tlb_invalid_l,
    input  logic        m0_tlb_invalid_s,
    input  logic        m0_tlb_mod,
    output logic        m1_valid,
    output logic [31:0] m1_paddr,
    output logic [31:0] m1_vaddr,
    output logic        m1_uncached,
    output logic        m1_exc,
    output logic [4:0]  m1_exccode,
    output logic [31:0] m1_badvaddr,
    output logic        m1_tlb_refill,
    output logic        m1_mem_req,
    output logic        m1_block,
    output logic [31:0] tlb_exc_cnt
);

    exc_info_t   excInfo;
    m1_state_e   state_q, state_d;
    logic        valid_q;
    logic [31:0] paddr_q, vaddr_q;
    logic        uncached_q, memOp_q, blockAtCap_q;
    exc_info_t   exc_q;
    logic        capture;

    tlb_exc_encode uEncode (
        .prev_exc_i     (m0_prev_exc),
        .prev_exccode_i (m0_prev_exccode),
        .refill_l_i     (m0_tlb_refill_l),
        .invalid_l_i    (m0_tlb_invalid_l),
        .refill_s_i     (m0_tlb_refill_s),
        .invalid_s_i    (m0_tlb_invalid_s),
        .mod_i          (m0_tlb_mod),
        .vaddr_i        (m0_vaddr),
        .info_o         (excInfo)
    );

    assign m1_allowin     = !valid_q || (m1_ready_go && m2_allowin);
    assign m1_to_m2_valid = valid_q && m1_ready_go;
    assign capture        = m0_to_m1_valid && m1_allowin && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (m1_allowin) begin
            valid_q <= m0_to_m1_valid;
        end
    end

    // blockAtCap_q snapshots the FSM so everything younger than an exception stays quiet
    always_ff @(posedge clk) begin
        if (reset) begin
            paddr_q      <= '0;
            vaddr_q      <= '0;
            uncached_q   <= 1'b0;
            memOp_q      <= 1'b0;
            blockAtCap_q <= 1'b0;
            exc_q        <= '0;
        end else if (capture) begin
            paddr_q      <= m0_paddr;
            vaddr_q      <= m0_vaddr;
            uncached_q   <= isKseg1(m0_vaddr);
            memOp_q      <= m0_is_load || m0_is_store || m0_is_cache;
            blockAtCap_q <= (state_q == BLOCK);
            exc_q        <= excInfo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OPEN;
        end else if (state_q == OPEN && capture && excInfo.exc) begin
            state_d = BLOCK;
        end
    end

`ifdef TLB_EXC_CNT_EN
    logic [31:0] cnt_q;
    logic        tlbCause;

    assign tlbCause = excInfo.exc && !m0_prev_exc;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (capture && tlbCause && cnt_q != 32'hFFFF_FFFF) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign tlb_exc_cnt = cnt_q;
`else
    assign tlb_exc_cnt = '0;
`endif

    assign m1_valid      = valid_q;
    assign m1_paddr      = paddr_q;
    assign m1_vaddr      = vaddr_q;
    assign m1_uncached   = uncached_q;
    assign m1_exc        = exc_q.exc;
    assign m1_exccode    = exc_q.exccode;
    assign m1_badvaddr   = exc_q.badVaddr;
    assign m1_tlb_refill = exc_q.tlbRefill;
    assign m1_block      = (state_q == BLOCK);
    assign m1_mem_req    = valid_q && !exc_q.exc && !blockAtCap_q && memOp_q;

endmodule

// File: tb/tb_mem0_mem1_reg.sv
// Directed, table-driven bench for mem0_mem1_reg plus hand sequences for block, backpressure, reset and counter.
module tb_mem0_mem1_reg;

    logic        clk = 1'b0;
    logic        reset, flush, m0_to_m1_valid, m1_ready_go, m2_allowin;
    logic        m1_allowin, m1_to_m2_valid;
    logic [31:0] m0_vaddr, m0_paddr;
    logic        m0_is_load, m0_is_store, m0_is_cache, m0_prev_exc;
    logic [4:0]  m0_prev_exccode;
    logic        m0_tlb_refill_l, m0_tlb_refill_s, m0_tlb_invalid_l, m0_tlb_invalid_s, m0_tlb_mod;
    logic        m1_valid, m1_uncached, m1_exc, m1_tlb_refill, m1_mem_req, m1_block;
    logic [31:0] m1_paddr, m1_vaddr, m1_badvaddr, tlb_exc_cnt;
    logic [4:0]  m1_exccode;

    int nVec  = 0;
    int nMiss = 0;

    always #5 clk = ~clk;

    mem0_mem1_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .m0_to_m1_valid(m0_to_m1_valid), .m1_allowin(m1_allowin),
        .m1_ready_go(m1_ready_go), .m2_allowin(m2_allowin), .m1_to_m2_valid(m1_to_m2_valid),
        .m0_vaddr(m0_vaddr), .m0_paddr(m0_paddr),
        .m0_is_load(m0_is_load), .m0_is_store(m0_is_store), .m0_is_cache(m0_is_cache),
        .m0_prev_exc(m0_prev_exc), .m0_prev_exccode(m0_prev_exccode),
        .m0_tlb_refill_l(m0_tlb_refill_l), .m0_tlb_refill_s(m0_tlb_refill_s),
        .m0_tlb_invalid_l(m0_tlb_invalid_l), .m0_tlb_invalid_s(m0_tlb_invalid_s),
        .m0_tlb_mod(m0_tlb_mod),
        .m1_valid(m1_valid), .m1_paddr(m1_paddr), .m1_vaddr(m1_vaddr),
        .m1_uncached(m1_uncached), .m1_exc(m1_exc), .m1_exccode(m1_exccode),
        .m1_badvaddr(m1_badvaddr), .m1_tlb_refill(m1_tlb_refill),
        .m1_mem_req(m1_mem_req), .m1_block(m1_block), .tlb_exc_cnt(tlb_exc_cnt)
    );

    // flags are {refill_l, invalid_l, refill_s, invalid_s, mod}
    typedef struct {
        logic        ld, st, ca;
        logic [31:0] va, pa;
        logic        pe;
        logic [4:0]  pc;
        logic [4:0]  fl;
        logic        eExc;
        logic [4:0]  eCode;
        logic        eRefill, eUnc, eMreq, eBlk;
        logic [31:0] eBad;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic ca,
                                 input logic [31:0] va, input logic [31:0] pa,
                                 input logic pe, input logic [4:0] pc, input logic [4:0] fl);
        m0_to_m1_valid   = 1'b1;
        m0_is_load       = ld;
        m0_is_store      = st;
        m0_is_cache      = ca;
        m0_vaddr         = va;
        m0_paddr         = pa;
        m0_prev_exc      = pe;
        m0_prev_exccode  = pc;
        m0_tlb_refill_l  = fl[4];
        m0_tlb_invalid_l = fl[3];
        m0_tlb_refill_s  = fl[2];
        m0_tlb_invalid_s = fl[1];
        m0_tlb_mod       = fl[0];
    endtask

    task automatic flushCycle();
        m0_to_m1_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1,0,0, 32'h0040_1234, 32'h0000_1234, 0, 5'd0,  5'b10000, 1, 5'd2,  1, 0, 0, 1, 32'h0040_1234};
        vecs[1]  = '{0,1,0, 32'hA000_0010, 32'h0000_0010, 0, 5'd0,  5'b00000, 0, 5'd0,  0, 1, 1, 0, 32'h0};
        vecs[2]  = '{0,1,0, 32'h0000_2000, 32'h0000_2000, 1, 5'd4,  5'b00001, 1, 5'd4,  0, 0, 0, 1, 32'h0};
        vecs[3]  = '{1,0,0, 32'h8000_1000, 32'h0000_1000, 0, 5'd0,  5'b01000, 1, 5'd2,  0, 0, 0, 1, 32'h8000_1000};
        vecs[4]  = '{0,1,0, 32'hBFC0_0000, 32'h1FC0_0000, 0, 5'd0,  5'b00100, 1, 5'd3,  1, 1, 0, 1, 32'hBFC0_0000};
        vecs[5]  = '{0,1,0, 32'h0040_3000, 32'h0000_3000, 0, 5'd0,  5'b00011, 1, 5'd3,  0, 0, 0, 1, 32'h0040_3000};
        vecs[6]  = '{0,1,0, 32'h1234_5678, 32'h0567_8000, 0, 5'd0,  5'b00001, 1, 5'd1,  0, 0, 0, 1, 32'h1234_5678};
        vecs[7]  = '{0,0,1, 32'h0000_0040, 32'h0000_0040, 0, 5'd0,  5'b00000, 0, 5'd0,  0, 0, 1, 0, 32'h0};
        vecs[8]  = '{0,0,0, 32'h0000_0080, 32'h0000_0080, 0, 5'd0,  5'b00000, 0, 5'd0,  0, 0, 0, 0, 32'h0};
        vecs[9]  = '{1,0,0, 32'h0050_0000, 32'h0000_5000, 0, 5'd0,  5'b01100, 1, 5'd2,  0, 0, 0, 1, 32'h0050_0000};
        vecs[10] = '{1,0,0, 32'hA000_1000, 32'h0000_1000, 1, 5'd10, 5'b10000, 1, 5'd10, 0, 1, 0, 1, 32'h0};

        reset = 1'b1; flush = 1'b0; m1_ready_go = 1'b1; m2_allowin = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 5'b00000);
        m0_to_m1_valid = 1'b0;
        step();
        step();
        reset = 1'b0;

        checkOutput("reset_state",
                    {m1_valid, m1_block, m1_mem_req, m1_exc, m1_allowin, m1_to_m2_valid},
                    {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        checkOutput("reset_payload", {m1_paddr, m1_badvaddr}, 64'h0);
        checkOutput("reset_cnt", tlb_exc_cnt, 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].ca, vecs[i].va, vecs[i].pa,
                          vecs[i].pe, vecs[i].pc, vecs[i].fl);
            step();
            checkOutput($sformatf("vec%0d", i),
                        {m1_valid, m1_to_m2_valid, m1_exc, m1_exccode, m1_tlb_refill, m1_uncached,
                         m1_mem_req, m1_block, m1_badvaddr},
                        {1'b1, 1'b1, vecs[i].eExc, vecs[i].eCode, vecs[i].eRefill, vecs[i].eUnc,
                         vecs[i].eMreq, vecs[i].eBlk, vecs[i].eBad});
            checkOutput($sformatf("vec%0d_addr", i), {m1_paddr, m1_vaddr}, {vecs[i].pa, vecs[i].va});
            flushCycle();
        end

        // exception blocks younger loads until flush; flush beats a same-cycle capture
        applyStimulus(1, 0, 0, 32'h0040_1234, 32'h0000_1234, 0, 5'd0, 5'b10000);
        step();
        checkOutput("blk_exc", {m1_exc, m1_block, m1_mem_req}, {1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 0, 32'h0000_1000 + i, 32'h0000_1000 + i, 0, 5'd0, 5'b00000);
            step();
            checkOutput($sformatf("blk_young%0d", i), {m1_valid, m1_exc, m1_block, m1_mem_req, m1_paddr},
                        {1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000 + i});
        end
        flush = 1'b1;
        applyStimulus(1, 0, 0, 32'h0000_7000, 32'h0000_7000, 0, 5'd0, 5'b10000);
        step();
        flush = 1'b0;
        checkOutput("blk_flush", {m1_valid, m1_block, m1_mem_req}, {1'b0, 1'b0, 1'b0});
        applyStimulus(1, 0, 0, 32'h0000_8000, 32'h0000_8000, 0, 5'd0, 5'b00000);
        step();
        checkOutput("blk_reopen", {m1_valid, m1_block, m1_mem_req}, {1'b1, 1'b0, 1'b1});

        // backpressure: outputs frozen, m0 ignored, then release
        applyStimulus(1, 0, 0, 32'h0000_1000, 32'h0000_2000, 0, 5'd0, 5'b00000);
        step();
        m1_ready_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 32'h0000_3000 + i, 32'h0000_4000 + i, 0, 5'd0, 5'b10000);
            step();
            checkOutput($sformatf("bp_hold%0d", i),
                        {m1_valid, m1_allowin, m1_to_m2_valid, m1_exc, m1_block, m1_mem_req, m1_paddr, m1_vaddr[15:0]},
                        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 16'h1000});
        end
        m1_ready_go = 1'b1;
        applyStimulus(1, 0, 0, 32'h0000_5100, 32'h0000_5000, 0, 5'd0, 5'b00000);
        step();
        checkOutput("bp_release", {m1_paddr, m1_vaddr}, {32'h0000_5000, 32'h0000_5100});

        // reset during backpressure drops the held instruction
        m1_ready_go = 1'b0;
        m0_to_m1_valid = 1'b0;
        step();
        checkOutput("rst_bp_held", {m1_valid, m1_mem_req}, {1'b1, 1'b1});
        reset = 1'b1;
        step();
        reset = 1'b0;
        m1_ready_go = 1'b1;
        checkOutput("rst_bp_drop", {m1_valid, m1_mem_req, m1_block, m1_paddr}, {1'b0, 1'b0, 1'b0, 32'h0});

        // counter: three TLB causes plus one older exception
        applyStimulus(1, 0, 0, 32'h0000_1000, 32'h0, 0, 5'd0, 5'b10000); step(); flushCycle();
        applyStimulus(0, 1, 0, 32'h0000_2000, 32'h0, 0, 5'd0, 5'b00010); step(); flushCycle();
        applyStimulus(0, 1, 0, 32'h0000_3000, 32'h0, 0, 5'd0, 5'b00001); step(); flushCycle();
        applyStimulus(1, 0, 0, 32'h0000_4000, 32'h0, 1, 5'd4, 5'b10000); step(); flushCycle();
`ifdef TLB_EXC_CNT_EN
        checkOutput("cnt_three", tlb_exc_cnt, 3);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        applyStimulus(1, 0, 0, 32'h0000_5000, 32'h0, 0, 5'd0, 5'b01000);
        step();
        checkOutput("cnt_sat", tlb_exc_cnt, 32'hFFFF_FFFF);
`else
        checkOutput("cnt_tied", tlb_exc_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
